// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer, in_ready back to the producer.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/sub, one CHUNK-bit slice per stage; PIPE_ADDER_OVF_EN adds signed overflow.
// Latency: WIDTH/CHUNK cycles from acceptance to visible result, 1 op/cycle.
// Backpressure: global stall (out_valid && !out_ready) freezes every stage; in_ready = !stall.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Operands are shifted right one slice per stage so slice k always sits at bit 0;
    // the result accumulates in place at its final bit position.
    typedef struct packed {
        logic             vld;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    logic             stall;
    logic             out_vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    stage_t d [STAGES];
    stage_t r [STAGES];

    assign stall        = out_vld_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    assign d[0] = {bus.in_valid, bus.cin ^ bus.sub, bus.a,
                   (bus.sub ? ~bus.b : bus.b), {WIDTH{1'b0}}};

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [CHUNK:0] add;

        assign add  = {1'b0, d[k].a[CHUNK-1:0]} + {1'b0, d[k].b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, d[k].c};
        assign r[k] = {d[k].vld, add[CHUNK], d[k].a >> CHUNK, d[k].b >> CHUNK,
                       d[k].s | (WIDTH'(add[CHUNK-1:0]) << (k * CHUNK))};
    end

    if (STAGES > 1) begin : g_mid
        stage_t q [STAGES-1];

        always_ff @(posedge clk) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                if (rst) begin
                    q[k] <= '0;
                end else if (!stall) begin
                    q[k] <= r[k];
                end
            end
        end

        for (genvar k = 1; k < STAGES; k++) begin : g_link
            assign d[k] = q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else if (!stall) begin
            out_vld_q <= r[LAST].vld;
            sum_q     <= r[LAST].s;
            cout_q    <= r[LAST].c;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // MSB sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered without a second adder.
    assign msb_cin = d[LAST].a[CHUNK-1] ^ d[LAST].b[CHUNK-1] ^ r[LAST].s[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= msb_cin ^ r[LAST].c;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4) against a fixed-latency delay-line model.
module tb_pipelined_adder;
    localparam int S = 4;

`ifdef PIPE_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t mdl [S];

    pipelined_adder_if #(.WIDTH(16)) bus ();

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [15:0] x, logic [15:0] y, logic ci, logic sb);
        exp_t m;
        int ux, uy, sx, sy, c, r, rs;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        c  = ci ? 1 : 0;
        if (sb) begin
            r   = ux - uy - c;
            rs  = sx - sy - c;
            m.c = (r >= 0);
        end else begin
            r   = ux + uy + c;
            rs  = sx + sy + c;
            m.c = (r > 65535);
        end
        m.v = 1'b1;
        m.s = r[15:0];
        m.o = OVF_ON && (rs > 32767 || rs < -32768);
        return m;
    endfunction

    // One clock: the model sees the same inputs the DUT samples at the edge; returns at the next negedge.
    task automatic step(output bit acc);
        bit st;
        st  = mdl[S-1].v && !bus.out_ready;
        acc = bus.in_valid && !st && !rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < S; i++) mdl[i] = '0;
        end else if (!st) begin
            for (int i = S - 1; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0] = bus.in_valid ? model(bus.a, bus.b, bus.cin, bus.sub) : '0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'b1; bus.sub = 1'b0;
        repeat (2) begin
            step(acc);
            checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b rdy=%b, want 0/0000/0/0/1",
                         bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready);
            end
        end
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step(acc);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: cycle %0d got out_valid=%b, want 0", n, bus.out_valid);
            end
        end
    endtask

    task automatic test_full_ripple();
        bit acc;
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step(acc);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== (n == 4)) begin
                errors++;
                $display("FAIL ripple_latency: cycle %0d got out_valid=%b, want %b", n, bus.out_valid, n == 4);
            end
            if (n == 4) begin
                checks++;
                if ({bus.sum, bus.cout, bus.ovf} !== {16'h0000, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL ripple_value: got sum=%h c=%b o=%b, want 0000/1/0", bus.sum, bus.cout, bus.ovf);
                end
            end
        end
    endtask

    task automatic test_streaming();
        bit acc;
        int k;
        k = 0;
        bus.out_ready = 1'b1; bus.sub = 1'b0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            bus.in_valid = (cyc < 16);
            bus.a = 16'(cyc); bus.b = 16'(3 * cyc); bus.cin = cyc[0];
            step(acc);
            checks++;
            if (bus.out_valid !== mdl[S-1].v || (mdl[S-1].v && {bus.sum, bus.cout, bus.ovf} !== {mdl[S-1].s, mdl[S-1].c, mdl[S-1].o})) begin
                errors++;
                $display("FAIL stream_model: cycle %0d got v=%b sum=%h, want v=%b sum=%h",
                         cyc, bus.out_valid, bus.sum, mdl[S-1].v, mdl[S-1].s);
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.sum !== 16'(4 * k + k % 2) || cyc != k + 3) begin
                    errors++;
                    $display("FAIL stream_order: op %0d at cycle %0d got sum=%h, want %h at cycle %0d",
                             k, cyc, bus.sum, 16'(4 * k + k % 2), k + 3);
                end
                k++;
            end
        end
        checks++;
        if (k != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d results, want 16", k);
        end
    endtask

    task automatic test_subtract();
        bit acc;
        bus.out_ready = 1'b1; bus.sub = 1'b1; bus.cin = 1'b0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            bus.in_valid = (cyc < 2);
            bus.a = (cyc == 0) ? 16'h0005 : 16'h8000;
            bus.b = (cyc == 0) ? 16'h0007 : 16'h0001;
            step(acc);
            checks++;
            if (bus.out_valid !== (cyc == 3 || cyc == 4)) begin
                errors++;
                $display("FAIL sub_valid: cycle %0d got out_valid=%b", cyc, bus.out_valid);
            end
            if (cyc == 3) begin
                checks++;
                if ({bus.sum, bus.cout, bus.ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL sub_borrow: got sum=%h c=%b o=%b, want fffe/0/0", bus.sum, bus.cout, bus.ovf);
                end
            end
            if (cyc == 4) begin
                checks++;
                if ({bus.sum, bus.cout, bus.ovf} !== {16'h7FFF, 1'b1, OVF_ON}) begin
                    errors++;
                    $display("FAIL sub_overflow: got sum=%h c=%b o=%b, want 7fff/1/%b", bus.sum, bus.cout, bus.ovf, OVF_ON);
                end
            end
        end
        bus.sub = 1'b0;
    endtask

    task automatic test_backpressure();
        bit acc;
        int sent, got;
        logic [15:0] held;
        sent = 0; got = 0; held = '0;
        bus.cin = 1'b0; bus.sub = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.in_valid  = (sent < 8);
            bus.a         = 16'(sent * 257);
            bus.b         = 16'(sent + 1);
            bus.out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            checks++;
            if (bus.in_ready !== !(mdl[S-1].v && !bus.out_ready) || ((cyc >= 5 && cyc <= 7) && bus.in_ready !== 1'b0)) begin
                errors++;
                $display("FAIL bp_in_ready: cycle %0d got %b", cyc, bus.in_ready);
            end
            if (cyc == 5) held = bus.sum;
            if (cyc == 6 || cyc == 7) begin
                checks++;
                if (bus.sum !== held || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got sum=%h v=%b, want %h/1", cyc, bus.sum, bus.out_valid, held);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (bus.sum !== 16'(got * 258 + 1)) begin
                    errors++;
                    $display("FAIL bp_order: delivery %0d got sum=%h, want %h", got, bus.sum, 16'(got * 258 + 1));
                end
                got++;
            end
            step(acc);
            if (acc) sent++;
            checks++;
            if (bus.out_valid !== mdl[S-1].v || (mdl[S-1].v && bus.sum !== mdl[S-1].s)) begin
                errors++;
                $display("FAIL bp_model: cycle %0d got v=%b sum=%h, want v=%b sum=%h",
                         cyc, bus.out_valid, bus.sum, mdl[S-1].v, mdl[S-1].s);
            end
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d deliveries, want 8", got);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        bit acc;
        bus.out_ready = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            bus.in_valid = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom);
            step(acc);
        end
        bus.in_valid = 1'b0; rst = 1'b1;
        step(acc);
        rst = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step(acc);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_flush: cycle %0d got out_valid=%b, want 0", cyc, bus.out_valid);
            end
        end
        bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step(acc);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== (n == 4) || (n == 4 && {bus.sum, bus.cout} !== {16'h5556, 1'b0})) begin
                errors++;
                $display("FAIL midreset_next: cycle %0d got v=%b sum=%h c=%b, want v=%b sum=5556 c=0",
                         n, bus.out_valid, bus.sum, bus.cout, n == 4);
            end
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = 16'($urandom);
            bus.b         = 16'($urandom);
            bus.cin       = 1'($urandom);
            bus.sub       = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (bus.in_ready !== !(mdl[S-1].v && !bus.out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready: cycle %0d got %b", cyc, bus.in_ready);
            end
            step(acc);
            checks++;
            if (bus.out_valid !== mdl[S-1].v || (mdl[S-1].v && {bus.sum, bus.cout, bus.ovf} !== {mdl[S-1].s, mdl[S-1].c, mdl[S-1].o})) begin
                errors++;
                $display("FAIL rand_result: cycle %0d got v=%b sum=%h c=%b o=%b, want v=%b sum=%h c=%b o=%b",
                         cyc, bus.out_valid, bus.sum, bus.cout, bus.ovf,
                         mdl[S-1].v, mdl[S-1].s, mdl[S-1].c, mdl[S-1].o);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < S; i++) mdl[i] = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_ripple();
        test_streaming();
        test_subtract();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit operation into CHUNK-bit slices, with one register stage per slice, so carry propagation across the full width is spread over WIDTH/CHUNK cycles. It accepts one operation per cycle under a valid/ready handshake with global stall. It is the scalable replacement for fixed-width adders built by chaining 4-bit adder slices, intended for datapaths where a full-width combinational carry chain misses timing.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, slice width per pipeline stage; STAGES = WIDTH/CHUNK (STAGES=1 legal).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  operation present on a/b/cin/sub.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at rising edge.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  signed overflow (see Configuration).

## Operation
- Effective operands: B' = sub ? ~b : b; C0 = sub ? ~cin : cin; result = a + B' + C0.
- Stage k (0..STAGES-1) adds slice k of A and B' with the carry registered from stage k-1 (stage 0 uses C0), registers its sum slice and carry.
- Input skew: the not-yet-consumed upper slices of A and B' travel with the op through the stage registers. Output deskew: the lower slices already computed travel forward. At the last stage, all slices of one op are aligned.
- One valid bit per stage. Ops stay strictly in order; bubbles are not compressed.
- Global stall = out_valid && !out_ready. On stall, every stage register and valid bit holds. in_ready = !stall.
- in_valid ignored when in_ready=0; a/b/cin/sub don't-care when in_valid=0.
- Reset: all valid bits cleared, all data and carry registers zeroed. In-flight ops are discarded, whether reset arrives mid-operation or during a stall.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 (with out_ready don't-care) from the first edge with rst=1.
- Latency: an op accepted at edge T appears with out_valid=1 after edge T+STAGES-1. Its result is visible in the cycle after edge T+STAGES-1, i.e. STAGES cycles after acceptance, plus one cycle per stall cycle.
- Throughput: 1 op/cycle when out_ready=1.
- During stall: sum/cout/ovf/out_valid held stable; no op lost or duplicated.
- in_ready is combinational from out_ready and out_valid (stall path). No other combinational input→output path.
- Carry into slice 0 when STAGES=1: single registered full-width add, latency 1.

## Configuration
- PIPE_ADDER_OVF_EN defined: ovf = carry into MSB XOR cout at the final stage, registered with the result and valid with out_valid. It requires an extra registered carry-into-MSB bit in the last stage.
- Not defined: ovf port still present, tied to 0; no extra logic.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1; nothing emerges after release.
- Full ripple (WIDTH=16, CHUNK=4): a=0xFFFF, b=0x0001, cin=0, sub=0 → 4 cycles later sum=0x0000, cout=1, ovf=0.
- Streaming: 16 back-to-back ops with a=i, b=3i, cin=i[0] → outputs in order, one per cycle, first at +4, each sum = 4i+i[0].
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0. a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1 (macro on) / 0 (macro off).
- Backpressure: stream 8 ops, drop out_ready for 3 cycles mid-stream → in_ready=0 for those cycles, sum held, all 8 results delivered exactly once, in order.
- Reset mid-flight: accept 3 ops, assert rst one cycle on the following edge → no out_valid for those ops; the next accepted op emerges at normal latency with the correct result.
